// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_ctrl
// Purpose  : Moore FSM sequencing a 4-bit calculator datapath through
//            LOAD1 -> LOAD2 -> EXEC -> WB -> OUT for each go request.
//            Optional macro CALC_CTRL_STEP_EN adds a `step` input that gates
//            every transition out of a non-IDLE state.
// Revision : 1.0 - initial release
// ============================================================================
module calc_ctrl #(
  parameter int OUT_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CALC_CTRL_STEP_EN
  input  logic       step,
`endif
  input  logic       go,
  input  logic [1:0] op,
  output logic [1:0] s1,
  output logic [1:0] wa,
  output logic       we,
  output logic [1:0] raa,
  output logic       rea,
  output logic [1:0] rab,
  output logic       reb,
  output logic [1:0] c,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    LOAD2 = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4,
    OUT   = 3'd5
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(OUT_HOLD - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [1:0] op_reg;
  logic [1:0] op_nxt;
  logic [3:0] hold_cnt;
  logic [3:0] hold_nxt;
  logic       advance;

`ifdef CALC_CTRL_STEP_EN
  // Non-IDLE states only move when the stepper allows it.
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  // State, captured op and OUT hold counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      op_reg    <= 2'b00;
      hold_cnt  <= 4'd0;
    end else begin
      cur_state <= nxt_state;
      op_reg    <= op_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

  // Next-state logic; illegal codes fall back to IDLE unconditionally.
  always_comb begin
    nxt_state = cur_state;
    op_nxt    = op_reg;
    hold_nxt  = hold_cnt;
    case (cur_state)
      IDLE: begin
        if (go) begin
          nxt_state = LOAD1;
          op_nxt    = op;
        end
      end
      LOAD1: if (advance) nxt_state = LOAD2;
      LOAD2: if (advance) nxt_state = EXEC;
      EXEC:  if (advance) nxt_state = WB;
      WB:    if (advance) nxt_state = OUT;
      OUT: begin
        if (advance) begin
          if (hold_cnt == HOLD_LAST) begin
            nxt_state = IDLE;
            hold_nxt  = 4'd0;
          end else begin
            hold_nxt  = hold_cnt + 4'd1;
          end
        end
      end
      default: begin
        nxt_state = IDLE;
        hold_nxt  = 4'd0;
      end
    endcase
  end

  // Moore output decode from registered state and registered op only.
  always_comb begin
    s1   = 2'b00;
    wa   = 2'b00;
    we   = 1'b0;
    raa  = 2'b00;
    rea  = 1'b0;
    rab  = 2'b00;
    reb  = 1'b0;
    c    = 2'b00;
    s2   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (cur_state)
      LOAD1: begin
        busy = 1'b1;
        s1   = 2'b11;
        wa   = 2'b01;
        we   = 1'b1;
      end
      LOAD2: begin
        busy = 1'b1;
        s1   = 2'b10;
        wa   = 2'b10;
        we   = 1'b1;
      end
      EXEC: begin
        busy = 1'b1;
        raa  = 2'b01;
        rea  = 1'b1;
        rab  = 2'b10;
        reb  = 1'b1;
        c    = op_reg;
      end
      WB: begin
        busy = 1'b1;
        raa  = 2'b01;
        rea  = 1'b1;
        rab  = 2'b10;
        reb  = 1'b1;
        c    = op_reg;
        s1   = 2'b00;
        wa   = 2'b11;
        we   = 1'b1;
      end
      OUT: begin
        busy = 1'b1;
        raa  = 2'b11;
        rea  = 1'b1;
        s2   = 1'b1;
        done = (hold_cnt == HOLD_LAST);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Moore FSM that sequences the 4-bit calculator datapath through one full operation per request.
- Sequence: load in1 into R1, load in2 into R2, execute the ALU op on R1/R2, write the result to R3, present R3 on `out`.
- Sits between the user-facing request interface (`go`/`op`) and the datapath control pins (`s1`, `wa`, `we`, `raa`, `rea`, `rab`, `reb`, `c`, `s2`).

Parameters:
- OUT_HOLD, 1, number of cycles the OUT state holds the result on `out` (legal range 1..15).

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, asynchronous active-high reset.
- go, input, 1, start request; sampled only in IDLE.
- op, input, 2, ALU op code (00 add, 01 sub, 10 and, 11 xor); captured with go.
- s1, output, 2, datapath write-mux select (11 in1, 10 in2, 00 ALU result).
- wa, output, 2, register-file write address.
- we, output, 1, register-file write enable.
- raa, output, 2, read port A address.
- rea, output, 1, read port A enable.
- rab, output, 2, read port B address.
- reb, output, 1, read port B enable.
- c, output, 2, ALU op select.
- s2, output, 1, output-mux select (0 forces `out`=0, 1 passes read port A).
- busy, output, 1, high from LOAD1 through OUT inclusive.
- done, output, 1, one-cycle pulse in the final OUT cycle.
- state, output, 3, current state encoding, for debug.

Behaviour:
- State encoding: IDLE=0, LOAD1=1, LOAD2=2, EXEC=3, WB=4, OUT=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- Reset (async, any state, mid-operation included):
  - state=IDLE, op register=00, hold counter=0.
  - All outputs 0.
  - The operation in progress is abandoned; no partial write is completed after reset deasserts.
- Outputs are decoded from the registered state and the registered op only, so they are glitch-free relative to `go`/`op`.
- Outputs not listed below are 0 in every state.
- IDLE:
  - All control outputs 0.
  - If go=1 at an edge: capture op, go to LOAD1. Otherwise stay.
- LOAD1: s1=11, wa=01, we=1. Next state LOAD2.
- LOAD2: s1=10, wa=10, we=1. Next state EXEC.
- EXEC:
  - raa=01, rea=1, rab=10, reb=1, c=op_reg.
  - Settle cycle; no write. Next state WB.
- WB: as EXEC, plus s1=00, wa=11, we=1 (ALU result written to R3). Next state OUT.
- OUT:
  - raa=11, rea=1, s2=1.
  - Hold counter counts 0..OUT_HOLD-1.
  - done=1 when the counter equals OUT_HOLD-1. On that edge go to IDLE and clear the counter.
- Latency: from the edge that samples go=1, LOAD1 is cycle 1 and done is high in cycle 4+OUT_HOLD. Default OUT_HOLD=1 gives cycle 5.
- Back-to-back operation: go is ignored while busy=1, and is not queued. go held high continuously starts a new operation on the edge after done, i.e. one IDLE cycle between operations.
- A change to op after capture has no effect until the next start.
- in1/in2 are not routed through this block. The requester holds in1 stable through LOAD1 and in2 stable through LOAD2.
- Arithmetic is performed by the datapath. Result width is 4 bits, wrap-around modulo 16 (e.g. 2-5 → 13).

Optional Feature:
- Macro: CALC_CTRL_STEP_EN.
- When defined:
  - Adds input port `step` (1 bit).
  - In every non-IDLE state, a state transition (and the OUT hold-counter increment) occurs only on an edge where step=1. Otherwise the state and all outputs hold.
  - IDLE→LOAD1 still requires only go=1.
  - Reset behaviour is unchanged.
- When undefined: no `step` port; the FSM advances every cycle as above.

Test Plan:
- Reset mid-op: go=1, op=00, assert rst during WB → next cycle state=0, all outputs 0, busy=0. After release, state stays IDLE with go=0.
- Add sequence, in1=3, in2=4, op=00, OUT_HOLD=1:
  - state sequence 1,2,3,4,5,0.
  - LOAD1 asserts s1=11/wa=01/we=1; WB asserts s1=00/wa=11/we=1/c=00.
  - With datapath attached, out=7 and done=1 in cycle 5.
- All ops on in1=2, in2=5: out=7 (op=00), 13 (op=01), 0 (op=10), 7 (op=11). done exactly once per operation.
- Busy behaviour: pulse go again during LOAD2 with op=11 → ignored, c stays the first op. go held high for 12 cycles → exactly two done pulses, 6 cycles apart.
- OUT_HOLD=3: s2=1 for 3 consecutive cycles; done only in the third; busy high for 7 cycles.
- With CALC_CTRL_STEP_EN: step=0 after go → state stays 1 for 10 cycles with we=1. Then step pulsed once per cycle → completes the normal sequence, one state per pulse.
